// File: rtl/store_rmw_pkg.sv
// Shared definitions for the store read-modify-write unit.
// The size codes are also used by the load-side sign/zero extender.
package store_rmw_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // A request is rejected when the access crosses its natural alignment
    // or uses the reserved size code.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Little-endian lane merge of narrow store data into the old memory word.
module store_merge
    import store_rmw_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    output logic [31:0] merged_o
);

    // Replace only the addressed lanes; every other lane keeps the old word.
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (addr_lo_i)
                    2'b00:   merged_o[7:0]   = data_i[7:0];
                    2'b01:   merged_o[15:8]  = data_i[7:0];
                    2'b10:   merged_o[23:16] = data_i[7:0];
                    2'b11:   merged_o[31:24] = data_i[7:0];
                    default: merged_o        = old_word_i;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = data_i[15:0];
                end else begin
                    merged_o[15:0]  = data_i[15:0];
                end
            end
            SZ_WORD: merged_o = data_i;
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/store_rmw.sv
// Store unit: word stores write directly, byte/half stores read the old word,
// merge the new lanes and write it back. Misaligned requests are rejected.
module store_rmw
    import store_rmw_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack,
    output logic              done,
    output logic              misalign
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              mis_q, mis_d;
    logic              req_mis_s;
    logic [31:0]       merged_s;

    assign req_mis_s = is_misaligned(req_size, req_addr[1:0]);

    store_merge u_merge (
        .old_word_i (mem_rdata),
        .data_i     (data_q),
        .addr_lo_i  (lane_q),
        .size_i     (size_q),
        .merged_o   (merged_s)
    );

    // Next-state and datapath capture; request fields are sampled only in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        size_d  = size_q;
        lane_d  = lane_q;
        mis_d   = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = req_data;
                    data_d  = req_data;
                    size_d  = req_size;
                    lane_d  = req_addr[1:0];
                    mis_d   = req_mis_s;
                    if (req_mis_s) begin
                        state_d = ST_DONE;
                    end else if (req_size == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_rvalid) begin
                    wdata_d = merged_s;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_wack) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            mis_q   <= mis_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_rd    = (state_q == ST_READ);
    assign mem_wr    = (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign misalign  = (state_q == ST_DONE) && mis_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_rmw.sv
// Table-driven bench for store_rmw with a reactive memory model and a
// scoreboard of expected write words.
module tb_store_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack;
    logic        done;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] mem_word;
        logic [31:0] exp_wdata;
        logic        exp_mis;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] waddr;
        logic        mis;
        logic        rd;
    } sb_t;

    vec_t vecs[12];
    sb_t  sb_q[$];

    store_rmw #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_wack   (mem_wack),
        .done       (done),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic run_req(input vec_t v, input int rdly, input int wdly, input bit noise);
        sb_t e;
        int  cyc;
        int  rw;
        int  ww;
        int  exp_lat;
        bit  seen_done;
        bit  saw_rd;
        bit  saw_wr;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        req_size  = v.size;
        e.wdata = v.exp_wdata;
        e.waddr = {v.addr[31:2], 2'b00};
        e.mis   = v.exp_mis;
        e.rd    = !v.exp_mis && (v.size != 2'b10);
        sb_q.push_back(e);
        exp_lat = v.lat + (v.exp_mis ? 0 : ((e.rd ? rdly : 0) + wdly));
        @(posedge clk);
        cyc = 1; rw = 0; ww = 0;
        seen_done = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
        while (!seen_done && cyc < 60) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_rvalid = 1'b0;
            mem_wack   = 1'b0;
            mem_rdata  = 32'h0BAD_F00D;
            if (done) begin
                seen_done = 1'b1;
                e = sb_q.pop_front();
                chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                chk("latency", cyc, exp_lat);
                chk("read_seen", {31'd0, saw_rd}, {31'd0, e.rd});
                chk("write_seen", {31'd0, saw_wr}, {31'd0, !e.mis});
            end else begin
                chk("ready_busy", {31'd0, req_ready}, 32'd0);
                if (mem_rd) begin
                    saw_rd = 1'b1;
                    chk("rd_addr", mem_addr, sb_q[0].waddr);
                    chk("rd_wr_excl", {31'd0, mem_wr}, 32'd0);
                    if (rw == rdly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.mem_word;
                    end else begin
                        rw++;
                        if (noise) begin
                            mem_wack  = 1'b1;
                            req_valid = 1'b1;
                            req_addr  = 32'h0000_0FF0;
                            req_data  = 32'hDEAD_DEAD;
                            req_size  = 2'b10;
                        end
                    end
                end else if (mem_wr) begin
                    saw_wr = 1'b1;
                    chk("wr_addr", mem_addr, sb_q[0].waddr);
                    chk("wr_data", mem_wdata, sb_q[0].wdata);
                    if (ww == wdly) begin
                        mem_wack = 1'b1;
                    end else begin
                        ww++;
                        if (noise) mem_rvalid = 1'b1;
                    end
                end
            end
            if (!seen_done) begin
                @(posedge clk);
                cyc++;
            end
        end
        if (!seen_done) begin
            chk("timeout_done", 32'd0, 32'd1);
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
        mem_wack   = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int  k;
        bit  found;
        sb_t dropped;
        vecs[0]  = '{32'h0000_0100, 32'h1234_5678, 2'b10, 32'h0000_0000, 32'h1234_5678, 1'b0, 2};
        vecs[1]  = '{32'h0000_0203, 32'h0000_00AB, 2'b00, 32'h1122_3344, 32'hAB22_3344, 1'b0, 3};
        vecs[2]  = '{32'h0000_0302, 32'hFFFF_BEEF, 2'b01, 32'hCAFE_1234, 32'hBEEF_1234, 1'b0, 3};
        vecs[3]  = '{32'h0000_0300, 32'hFFFF_BEEF, 2'b01, 32'hCAFE_1234, 32'hCAFE_BEEF, 1'b0, 3};
        vecs[4]  = '{32'h0000_0101, 32'h0000_1111, 2'b01, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[5]  = '{32'h0000_0102, 32'h2222_2222, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[6]  = '{32'h0000_0100, 32'h3333_3333, 2'b11, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[7]  = '{32'h0000_0200, 32'h0000_0055, 2'b00, 32'h1122_3344, 32'h1122_3355, 1'b0, 3};
        vecs[8]  = '{32'h0000_0201, 32'h0000_0066, 2'b00, 32'h1122_3344, 32'h1122_6644, 1'b0, 3};
        vecs[9]  = '{32'h0000_0202, 32'h0000_0077, 2'b00, 32'h1122_3344, 32'h1177_3344, 1'b0, 3};
        vecs[10] = '{32'h0000_0403, 32'h4444_4444, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[11] = '{32'h0000_0001, 32'hFFFF_FF99, 2'b00, 32'h0000_0000, 32'h0000_9900, 1'b0, 3};

        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_size = 2'b00;
        mem_rdata = 32'h0; mem_rvalid = 1'b0; mem_wack = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i], 0, 0, 1'b0);
        end

        // Stalled memory with stray handshakes and a request presented while busy.
        run_req(vecs[1], 3, 4, 1'b1);
        run_req(vecs[2], 2, 1, 1'b1);

        // Reset in the middle of a byte store's write phase.
        req_valid = 1'b1; req_addr = 32'h0000_0203; req_data = 32'h0000_00AB; req_size = 2'b00;
        sb_q.push_back('{32'hAB22_3344, 32'h0000_0200, 1'b0, 1'b1});
        @(posedge clk);
        k = 0; found = 1'b0;
        while (!found && k < 20) begin
            @(negedge clk);
            req_valid = 1'b0; mem_rvalid = 1'b0;
            if (mem_rd) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h1122_3344;
            end else if (mem_wr) begin
                found = 1'b1;
            end
            if (!found) begin
                @(posedge clk);
                k++;
            end
        end
        chk("rst_reach_write", {31'd0, found}, 32'd1);
        chk("rst_pre_wdata", mem_wdata, 32'hAB22_3344);
        mem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_async_done", {31'd0, done}, 32'd0);
        chk("rst_async_addr", mem_addr, 32'd0);
        chk("rst_async_wdata", mem_wdata, 32'd0);
        dropped = sb_q.pop_front();
        @(negedge clk);
        rst = 1'b0;
        mem_wack = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("post_rst_no_done", {31'd0, done}, 32'd0);
            chk("post_rst_no_wr", {31'd0, mem_wr}, 32'd0);
            chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        end
        mem_wack = 1'b0;
        run_req(vecs[8], 0, 1, 1'b0);
        run_req(vecs[0], 0, 0, 1'b0);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
